module_keypad_scan_ctrl: RTL and testbench
==========================================

// Module: module_keypad_scan_ctrl
// PURPOSE
//  Sequencer for the 4x4 keypad scan datapath. Steps the column select (C1:C0) through the decoder,
//  waits for row settling, then debounces the hit. Hands one 4-bit key code per press to the calculator
//  over a valid/ready handshake, then waits for debounced release before rescanning.
//  Sits between the raw row pins/column decoder and the calculator input FSM.
// PARAMETERS
//  SETTLE_CYCLES    1000     clk_10m cycles a column is driven before rows are sampled (100 us)
//  DEBOUNCE_CYCLES  100000   press/release must be stable this many cycles (10 ms)
// PORTS
//  clk_10m    in   1  10 MHz clock, single clock domain
//  reset      in   1  asynchronous, active-high reset
//  rows       in   4  raw keypad rows F3..F0, active-high (key closes driven column to row), async
//  col_sel    out  2  column index to 2-to-4 decoder, {C1,C0}
//  key_code   out  4  {col[1:0], row_idx[1:0]}, stable while key_valid=1
//  key_valid  out  1  key_code available
//  key_ready  in   1  consumer accepts; transfer when key_valid & key_ready on a rising edge
//  key_down   out  1  1 from handshake-pending through end of release debounce
//  overrun    out  1  sticky; set if a new press is debounced while previous code untaken (see below)
// BEHAVIOUR
//  Reset (async assert, sync deassert-safe): state=SCAN, col_sel=0, counters=0, key_code=0,
//   key_valid=0, key_down=0, overrun=0. Reset mid-operation discards any pending code.
//  rows pass a 2-FF synchronizer; all decisions use synced rows (2-cycle input latency).
//  States:
//   SCAN     : drive col_sel; count SETTLE_CYCLES-1 then sample. Any row high -> latch col, row_idx
//              (priority: lowest row index wins on multiple hits), go DEBOUNCE. None -> col_sel+1
//              (3 wraps to 0), restart settle count.
//   DEBOUNCE : col_sel held. Latched row must stay high every cycle for DEBOUNCE_CYCLES.
//              Drop at any cycle -> SCAN, same column, settle restarts. Completion -> PRESENT,
//              key_code <= {col,row_idx}, key_valid <= 1 on the same edge.
//   PRESENT  : key_valid=1, key_down=1, key_code frozen. key_ready sampled 1 -> key_valid=0 next
//              cycle, go RELEASE. Key release while waiting does NOT cancel the code.
//   RELEASE  : col_sel held; all four rows low continuously for DEBOUNCE_CYCLES -> SCAN with
//              col_sel+1 (wrap), key_down=0. Any row high restarts the release count.
//  key_ready while key_valid=0 is ignored. key_ready held high constantly -> transfer on the
//   first key_valid cycle (1-cycle valid pulse).
//  overrun: cannot occur in this FSM (no scan during PRESENT); kept as a sticky 0 output.
//   Cleared only by reset; reserved for a future buffered variant.
//  Press-to-valid latency: 2 (sync) + remaining settle + DEBOUNCE_CYCLES + 1 cycles.
//  Counters: width $clog2(max(SETTLE_CYCLES,DEBOUNCE_CYCLES)+1); a counter saturating at
//   terminal count is an error. Each counter clears on every state entry.
//  Every output is driven from a flop; no combinational path from rows or key_ready to outputs.
// STRUCTURE
//  keypad_pkg: typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESENT, RELEASE} kp_state_t;
//   localparams NUM_ROWS=4, NUM_COLS=4, KEY_CODE_W=4; function row_prio_enc(4b)->2b.
//  Sub-module: module_row_sync (4-bit 2-FF synchronizer, async active-high reset to 0).
//  One FSM always_ff plus next-state always_comb; single shared cycle counter.
// TESTING (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8 in bench)
//  1 Idle rows=0 for 40 cycles -> col_sel cycles 0,1,2,3,0 every 4 cycles; key_valid stays 0.
//  2 rows=4'b0100 while col_sel=2, held, key_ready=1 -> key_valid single-cycle pulse, key_code=4'b1010;
//    release -> after 8 low cycles key_down=0, col_sel=3.
//  3 Bounce: rows[1] high 3 cycles, low 1, high on col 1 -> no valid until 8 contiguous high
//    cycles; then key_code=4'b0101.
//  4 rows=4'b1010 on col 3, key_ready=0 for 50 cycles -> key_code=4'b1101 (row 1 wins), valid held
//    stable; release rows mid-wait; assert key_ready -> transfer, FSM enters RELEASE.
//  5 Reset pulse during PRESENT (async, mid-cycle) -> key_valid, key_down, col_sel drop to 0
//    immediately; after release scan restarts at col 0.
//  6 Release glitch: in RELEASE, rows high 1 cycle at count 6 -> count restarts; needs 8 clean
//    cycles before SCAN.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 keypad scan controller.
//   kp_state_t   : scan sequencer states
//   NUM_ROWS/NUM_COLS/KEY_CODE_W : keypad geometry and key code width
//   row_prio_enc : picks the lowest-index active row when several are high
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESENT, RELEASE} kp_state_t;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    // Scans from the top down so the lowest set bit is the last assignment.
    function automatic logic [1:0] row_prio_enc(input logic [NUM_ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/module_keypad_scan_ctrl_if.sv
// module_keypad_scan_ctrl_if
//   Key hand-off bundle between the keypad scanner and the calculator.
//   key_code  : {col, row_idx}, stable while key_valid
//   key_valid : code available
//   key_ready : consumer accepts (transfer on key_valid & key_ready)
//   key_down  : key held from hand-off through release debounce
//   overrun   : sticky lost-code flag
//   master = scanner side, slave = consumer side
interface module_keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_ready;
    logic                  key_down;
    logic                  overrun;

    modport master (output key_code, key_valid, key_down, overrun, input key_ready);
    modport slave  (input key_code, key_valid, key_down, overrun, output key_ready);

endinterface

// File: rtl/module_row_sync.sv
// module_row_sync
//   Two-flop synchronizer for the asynchronous keypad row pins.
//   clk : sampling clock
//   rst : async active-high reset, clears both stages
//   d   : raw rows
//   q   : synchronized rows (2-cycle latency)
module module_row_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_keypad_scan_ctrl.sv
// module_keypad_scan_ctrl
//   Scan sequencer for a 4x4 keypad: walks the column decoder, samples the
//   rows after a settle time, debounces the hit, hands one key code per press
//   to the consumer, then waits for a debounced release before rescanning.
//   clk_10m : 10 MHz clock
//   reset   : async active-high reset
//   rows    : raw row pins, active-high, asynchronous
//   col_sel : column index to the 2-to-4 decoder
//   key_if  : key_code/key_valid/key_ready/key_down/overrun hand-off
module module_keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                             clk_10m,
    input  logic                             reset,
    input  logic [NUM_ROWS-1:0]              rows,
    output logic [$clog2(NUM_COLS)-1:0]      col_sel,
    module_keypad_scan_ctrl_if.master        key_if
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int COL_W   = $clog2(NUM_COLS);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0]   rows_s;
    kp_state_t             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [COL_W-1:0]      col_nxt;
    logic [1:0]            row_idx, row_idx_nxt;
    logic [KEY_CODE_W-1:0] code_nxt;
    logic                  valid_nxt;
    logic                  down_nxt;

    module_row_sync #(.W(NUM_ROWS)) u_row_sync (
        .clk (clk_10m),
        .rst (reset),
        .d   (rows),
        .q   (rows_s)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        col_nxt     = col_sel;
        row_idx_nxt = row_idx;
        code_nxt    = key_if.key_code;
        valid_nxt   = key_if.key_valid;
        down_nxt    = key_if.key_down;
        case (state)
            SCAN: begin
                // Each column is driven SETTLE_CYCLES cycles; the last one samples.
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt = '0;
                    if (|rows_s) begin
                        row_idx_nxt = row_prio_enc(rows_s);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_nxt = col_sel + COL_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                // Any drop of the latched row rescans the same column.
                if (!rows_s[row_idx]) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESENT;
                    cnt_nxt   = '0;
                    code_nxt  = {col_sel, row_idx};
                    valid_nxt = 1'b1;
                    down_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                // Code stays up until taken, even if the key is let go meanwhile.
                if (key_if.key_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (|rows_s) begin
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    col_nxt   = col_sel + COL_W'(1);
                    down_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_10m or posedge reset) begin
        if (reset) begin
            state            <= SCAN;
            cnt              <= '0;
            col_sel          <= '0;
            row_idx          <= '0;
            key_if.key_code  <= '0;
            key_if.key_valid <= 1'b0;
            key_if.key_down  <= 1'b0;
            key_if.overrun   <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            col_sel          <= col_nxt;
            row_idx          <= row_idx_nxt;
            key_if.key_code  <= code_nxt;
            key_if.key_valid <= valid_nxt;
            key_if.key_down  <= down_nxt;
            // No scanning happens while a code is pending, so nothing can be lost.
            key_if.overrun   <= key_if.overrun;
        end
    end

endmodule

// File: tb/tb_module_keypad_scan_ctrl.sv
// tb_module_keypad_scan_ctrl
//   Directed bench for the keypad scan controller with SETTLE_CYCLES=4,
//   DEBOUNCE_CYCLES=8. Inputs change and outputs are sampled 1 time unit
//   after the rising clock edge.
module tb_module_keypad_scan_ctrl;

    logic       clk_10m = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] rows    = 4'h0;
    logic [1:0] col_sel;

    int n_vec = 0;
    int n_err = 0;

    module_keypad_scan_ctrl_if kif();

    module_keypad_scan_ctrl #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_10m (clk_10m),
        .reset   (reset),
        .rows    (rows),
        .col_sel (col_sel),
        .key_if  (kif)
    );

    always #50 clk_10m = ~clk_10m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_10m);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(kif.key_valid), 32'd1);
    endtask

    task automatic wait_col(input string tag, input logic [1:0] c);
        int n;
        n = 0;
        while (col_sel !== c && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(col_sel), 32'(c));
    endtask

    task automatic wait_kd0(input string tag);
        int n;
        n = 0;
        while (kif.key_down !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(kif.key_down), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_ready = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_col", 32'(col_sel), 32'd0);
        chk("rst_code", 32'(kif.key_code), 32'd0);
        chk("rst_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_down", 32'(kif.key_down), 32'd0);
        chk("rst_ovr", 32'(kif.overrun), 32'd0);
        reset = 1'b0;

        // 1: idle scan, column advances every 4 cycles
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("idle_col", 32'(col_sel), 32'((i / 4) % 4));
            chk("idle_valid", 32'(kif.key_valid), 32'd0);
        end

        // 2: key on col 2 row 2, consumer always ready
        rows = 4'b0100;
        kif.key_ready = 1'b1;
        wait_valid("t2_valid");
        chk("t2_code", 32'(kif.key_code), 32'hA);
        chk("t2_down", 32'(kif.key_down), 32'd1);
        tick();
        chk("t2_pulse", 32'(kif.key_valid), 32'd0);
        chk("t2_down_hold", 32'(kif.key_down), 32'd1);
        rows = 4'b0000;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 9) chk("t2_down_t9", 32'(kif.key_down), 32'd1);
            if (t == 10) begin
                chk("t2_down_t10", 32'(kif.key_down), 32'd0);
                chk("t2_col_next", 32'(col_sel), 32'd3);
            end
        end

        // 3: bouncing row 1 on col 1
        wait_col("t3_col", 2'd1);
        rows = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk("t3_no_valid", 32'(kif.key_valid), 32'd0);
            chk("t3_col_hold", 32'(col_sel), 32'd1);
            if (e == 3) rows = 4'b0000;
            if (e == 4) rows = 4'b0010;
        end
        wait_valid("t3_valid");
        chk("t3_code", 32'(kif.key_code), 32'h5);
        tick();
        chk("t3_pulse", 32'(kif.key_valid), 32'd0);
        rows = 4'b0000;
        wait_kd0("t3_release");
        chk("t3_col_next", 32'(col_sel), 32'd2);

        // 4: two rows on col 3, consumer stalls, key released while waiting
        kif.key_ready = 1'b0;
        wait_col("t4_col", 2'd3);
        rows = 4'b1010;
        wait_valid("t4_valid");
        chk("t4_code", 32'(kif.key_code), 32'hD);
        chk("t4_down", 32'(kif.key_down), 32'd1);
        for (int i = 1; i <= 50; i++) begin
            tick();
            chk("t4_valid_hold", 32'(kif.key_valid), 32'd1);
            chk("t4_code_hold", 32'(kif.key_code), 32'hD);
            if (i == 20) rows = 4'b0000;
        end
        kif.key_ready = 1'b1;
        tick();
        chk("t4_xfer", 32'(kif.key_valid), 32'd0);
        chk("t4_release_st", 32'(kif.key_down), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("t4_down_t7", 32'(kif.key_down), 32'd1);
            if (i == 8) begin
                chk("t4_down_t8", 32'(kif.key_down), 32'd0);
                chk("t4_col_wrap", 32'(col_sel), 32'd0);
            end
        end

        // 5: async reset while a code is pending on col 2
        kif.key_ready = 1'b0;
        wait_col("t5_col", 2'd2);
        rows = 4'b0010;
        wait_valid("t5_valid");
        chk("t5_code", 32'(kif.key_code), 32'h9);
        #30;
        reset = 1'b1;
        rows  = 4'b0000;
        #1;
        chk("t5_rst_valid", 32'(kif.key_valid), 32'd0);
        chk("t5_rst_down", 32'(kif.key_down), 32'd0);
        chk("t5_rst_col", 32'(col_sel), 32'd0);
        chk("t5_rst_code", 32'(kif.key_code), 32'd0);
        tick();
        reset = 1'b0;
        kif.key_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("t5_rescan_col", 32'(col_sel), 32'((i / 4) % 4));
            chk("t5_rescan_valid", 32'(kif.key_valid), 32'd0);
        end

        // 6: one-cycle glitch during release debounce restarts the count
        wait_col("t6_col", 2'd0);
        rows = 4'b1000;
        wait_valid("t6_valid");
        chk("t6_code", 32'(kif.key_code), 32'h3);
        rows = 4'b0000;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 1) chk("t6_pulse", 32'(kif.key_valid), 32'd0);
            if (t == 6) rows = 4'b1000;
            if (t == 7) rows = 4'b0000;
            if (t == 10) chk("t6_down_t10", 32'(kif.key_down), 32'd1);
            if (t == 16) chk("t6_down_t16", 32'(kif.key_down), 32'd1);
            if (t == 17) begin
                chk("t6_down_t17", 32'(kif.key_down), 32'd0);
                chk("t6_col_next", 32'(col_sel), 32'd1);
            end
        end
        chk("end_ovr", 32'(kif.overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
